uart_link_peer: RTL

Far-end UART endpoint for the controller's serial link. It receives 16-byte frames and assembles each into one 128-bit word. It transmits 16-bit words as 2 bytes, low byte first. It contains its own 16x-oversampled baud timing and lives in the testbench/host-model side of the system.

---
 rtl/uart_link_pkg.sv | 12 +
 rtl/uart_link_peer_rx_byte.sv | 79 +++++++
 rtl/uart_link_peer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_link_pkg.sv
// Shared types and constants for the UART link peer: byte-level FSM states
// and the oversampling tick positions used by both directions.
package uart_link_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_fsm_t;

    localparam int OS_RATE     = 16;
    localparam int FRAME_BYTES = 16;
    localparam int WORD_BYTES  = 2;

    localparam logic [3:0] START_SAMPLE = 4'd7;
    localparam logic [3:0] LAST_TICK    = 4'd15;
endpackage

// File: rtl/uart_link_peer_rx_byte.sv
// Serial receiver for one byte: rx synchroniser plus the oversampled
// start/data/stop state machine, advanced only on shared baud ticks.
module uart_rx_byte
    import uart_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       stop_err,
    output logic       start_det,
    output logic       fsm_idle
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    byte_fsm_t              state;
    logic [3:0]             tick_cnt;
    logic [2:0]             bit_idx;

    assign rx_s      = sync[SYNC_STAGES-1];
    assign fsm_idle  = (state == IDLE);
    assign start_det = fsm_idle && tick && !rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '1;
        else     sync <= {sync[SYNC_STAGES-2:0], rx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            byte_data <= '0;
            byte_done <= 1'b0;
            stop_err  <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            stop_err  <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                    // A start bit that is high again at mid-bit is a glitch.
                    START: if (tick_cnt == START_SAMPLE) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                    DATA: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == LAST_TICK) begin
                            byte_data[bit_idx] <= rx_s;
                            bit_idx            <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) state <= STOP;
                        end
                    end
                    STOP: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == LAST_TICK) begin
                            byte_done <= rx_s;
                            stop_err  <= !rx_s;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/uart_link_peer.sv
// Far-end UART endpoint: assembles 16-byte received frames into one word and
// serialises 16-bit words low byte first, using its own oversampled baud tick.
module uart_link_peer
    import uart_link_pkg::*;
#(
    parameter int TIMEOUT_BITS = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              baud_divisor,
    input  logic                     rx,
    output logic                     tx,
    output logic [8*FRAME_BYTES-1:0] frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    input  logic [8*WORD_BYTES-1:0]  word_data,
    input  logic                     word_valid,
    output logic                     word_ready,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     rx_busy
);
    localparam int TO_TICKS = TIMEOUT_BITS * OS_RATE;
    localparam int TO_W     = $clog2(TO_TICKS + 1);
    localparam int SEL_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WORD_BYTES - 1);

    logic [15:0] div_cnt;
    logic [15:0] div_cur;
    logic        tick;

    // The divisor is sampled at each wrap so a change never shortens a tick.
    assign tick = (div_cnt >= div_cur);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            div_cur <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            div_cur <= baud_divisor;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       stop_err;
    logic       start_det;
    logic       rx_idle;

    uart_rx_byte #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rx        (rx),
        .byte_data (rx_byte),
        .byte_done (byte_done),
        .stop_err  (stop_err),
        .start_det (start_det),
        .fsm_idle  (rx_idle)
    );

    logic [3:0]                     byte_cnt;
    logic [8*(FRAME_BYTES-1)-1:0]   assembly;
    logic [TO_W-1:0]                to_cnt;
    logic                           to_counting;
    logic                           to_fire;

    assign rx_busy     = (byte_cnt != 4'd0);
    assign to_counting = rx_busy && rx_idle && !start_det;
    assign to_fire     = to_counting && tick && (to_cnt == TO_W'(TO_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt    <= '0;
            assembly    <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            to_cnt      <= '0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (frame_valid && frame_ready) frame_valid <= 1'b0;

            if (byte_done) begin
                if (byte_cnt == 4'(FRAME_BYTES - 1)) begin
                    byte_cnt <= '0;
                    // Acceptance in this same cycle frees the output for the new frame.
                    if (!frame_valid || frame_ready) begin
                        frame_data  <= {rx_byte, assembly};
                        frame_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    assembly[8*byte_cnt +: 8] <= rx_byte;
                    byte_cnt                  <= byte_cnt + 4'd1;
                end
            end else if (stop_err || to_fire) begin
                frame_err <= 1'b1;
                byte_cnt  <= '0;
            end

            if (!to_counting)  to_cnt <= '0;
            else if (to_fire)  to_cnt <= '0;
            else if (tick)     to_cnt <= to_cnt + 1'b1;
        end
    end

    byte_fsm_t                tx_state;
    logic [3:0]               tx_tick_cnt;
    logic [2:0]               tx_bit;
    logic [SEL_W-1:0]         tx_sel;
    logic [8*WORD_BYTES-1:0]  tx_word;
    logic [7:0]               tx_byte;

    assign tx_byte = tx_word[8*tx_sel +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= IDLE;
            tx_tick_cnt <= '0;
            tx_bit      <= '0;
            tx_sel      <= '0;
            tx_word     <= '0;
            tx          <= 1'b1;
            word_ready  <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: if (word_valid && word_ready) begin
                    tx_word     <= word_data;
                    tx_sel      <= '0;
                    tx_tick_cnt <= '0;
                    tx          <= 1'b0;
                    word_ready  <= 1'b0;
                    tx_state    <= START;
                end
                START: if (tick) begin
                    tx_tick_cnt <= tx_tick_cnt + 4'd1;
                    if (tx_tick_cnt == LAST_TICK) begin
                        tx_bit   <= '0;
                        tx       <= tx_byte[0];
                        tx_state <= DATA;
                    end
                end
                DATA: if (tick) begin
                    tx_tick_cnt <= tx_tick_cnt + 4'd1;
                    if (tx_tick_cnt == LAST_TICK) begin
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx     <= tx_byte[tx_bit + 3'd1];
                        end
                    end
                end
                // Bytes of one word go back to back with no idle gap.
                STOP: if (tick) begin
                    tx_tick_cnt <= tx_tick_cnt + 4'd1;
                    if (tx_tick_cnt == LAST_TICK) begin
                        if (tx_sel != LAST_SEL) begin
                            tx_sel   <= tx_sel + 1'b1;
                            tx       <= 1'b0;
                            tx_state <= START;
                        end else begin
                            word_ready <= 1'b1;
                            tx_state   <= IDLE;
                        end
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end
endmodule
